edge_event_arbiter: RTL and testbench

- Multi-channel edge-event controller.
- Watches N_CH synchronous input lines and detects rising and/or falling edges per channel, as selected by configuration.
- Holds one pending event per channel.
- Shares a single event output channel between all channels using round-robin arbitration and a valid/ready handshake.
- Sits between the synchronised GPIO/button inputs and the event-consuming logic, replacing ad hoc per-signal edge detectors.

---
 rtl/edge_evt_pkg.sv | 12 +
 rtl/edge_event_arbiter_chan.sv | 63 ++++++
 rtl/edge_event_arbiter.sv | 91 +++++++++
 tb/tb_edge_event_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/edge_evt_pkg.sv
// Shared constants for the edge-event arbiter: per-channel edge modes and event polarity.
package edge_evt_pkg;

   localparam logic [1:0] EDGE_OFF  = 2'b00;
   localparam logic [1:0] EDGE_RISE = 2'b01;
   localparam logic [1:0] EDGE_FALL = 2'b10;
   localparam logic [1:0] EDGE_BOTH = 2'b11;

   localparam logic EVT_RISE = 1'b1;
   localparam logic EVT_FALL = 1'b0;

endpackage

// File: rtl/edge_event_arbiter_chan.sv
// One monitored line: edge detection, a single pending-event slot and a sticky overflow flag.
module edge_chan
   import edge_evt_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       sig,
   input  logic [1:0] sel,
   input  logic       grant,
   input  logic       ovf_clr,
   output logic       pending,
   output logic       ptype,
   output logic       ovf
);

   logic prev_q;
   logic pend_q, pend_d;
   logic ptype_q, ptype_d;
   logic ovf_q, ovf_d;
   logic rise, fall, hit;

   always_comb begin
      rise    = sig & ~prev_q;
      fall    = ~sig & prev_q;
      hit     = (rise & ((sel == EDGE_RISE) | (sel == EDGE_BOTH)))
              | (fall & ((sel == EDGE_FALL) | (sel == EDGE_BOTH)));
      pend_d  = pend_q;
      ptype_d = ptype_q;
      ovf_d   = ovf_q & ~ovf_clr;
      if (sel == EDGE_OFF) begin
         pend_d = 1'b0;
      end else if (hit) begin
         // A grant in the same cycle frees the slot, so the new edge reloads it.
         if (!pend_q || grant) begin
            pend_d  = 1'b1;
            ptype_d = rise ? EVT_RISE : EVT_FALL;
         end else begin
            ovf_d = 1'b1;
         end
      end else if (grant) begin
         pend_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prev_q  <= 1'b0;
         pend_q  <= 1'b0;
         ptype_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         prev_q  <= sig;
         pend_q  <= pend_d;
         ptype_q <= ptype_d;
         ovf_q   <= ovf_d;
      end
   end

   assign pending = pend_q;
   assign ptype   = ptype_q;
   assign ovf     = ovf_q;

endmodule

// File: rtl/edge_event_arbiter.sv
// Multi-channel edge-event controller: per-channel detectors feeding one registered
// valid/ready event output through a round-robin arbiter.
module edge_event_arbiter
   import edge_evt_pkg::*;
#(
   parameter  int N_CH = 4,
   localparam int ID_W = $clog2(N_CH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [N_CH-1:0]   sig_in,
   input  logic [2*N_CH-1:0] edge_sel,
   output logic              evt_valid,
   input  logic              evt_ready,
   output logic [ID_W-1:0]   evt_id,
   output logic              evt_rise,
   output logic [N_CH-1:0]   ovf,
   input  logic [N_CH-1:0]   ovf_clr
);

   logic [N_CH-1:0] pend, ptype, grant;
   logic            valid_q, valid_d, rise_q, rise_d;
   logic [ID_W-1:0] id_q, id_d, ptr_q, ptr_d;
   logic [ID_W-1:0] win_id, cand;
   logic            win_found, load;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      edge_chan u_chan (
         .clk     (clk),
         .reset   (reset),
         .sig     (sig_in[i]),
         .sel     (edge_sel[2*i +: 2]),
         .grant   (grant[i]),
         .ovf_clr (ovf_clr[i]),
         .pending (pend[i]),
         .ptype   (ptype[i]),
         .ovf     (ovf[i])
      );
   end

   // Search starts one past the last winner so every pending channel is served in turn.
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      cand      = '0;
      for (int k = 1; k <= N_CH; k++) begin
         cand = ID_W'((int'(ptr_q) + k) % N_CH);
         if (!win_found && pend[cand]) begin
            win_found = 1'b1;
            win_id    = cand;
         end
      end
   end

   always_comb begin
      load    = (~valid_q | evt_ready) & win_found;
      grant   = '0;
      valid_d = valid_q;
      id_d    = id_q;
      rise_d  = rise_q;
      ptr_d   = ptr_q;
      if (load) begin
         grant[win_id] = 1'b1;
         valid_d       = 1'b1;
         id_d          = win_id;
         rise_d        = ptype[win_id];
         ptr_d         = win_id;
      end else if (evt_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= 1'b0;
         id_q    <= '0;
         rise_q  <= 1'b0;
         ptr_q   <= ID_W'(N_CH - 1);
      end else begin
         valid_q <= valid_d;
         id_q    <= id_d;
         rise_q  <= rise_d;
         ptr_q   <= ptr_d;
      end
   end

   assign evt_valid = valid_q;
   assign evt_id    = id_q;
   assign evt_rise  = rise_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Bench for edge_event_arbiter: directed vector table, reset-under-stall sequence and
// randomized traffic against an event-level reference model.
`timescale 1ns/1ps
module tb_edge_event_arbiter;

   localparam int N = 4;

   logic         clk = 1'b0;
   logic         reset;
   logic [N-1:0] sig_in;
   logic [7:0]   edge_sel;
   logic         evt_valid, evt_ready, evt_rise;
   logic [1:0]   evt_id;
   logic [N-1:0] ovf, ovf_clr;

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model state
   logic [N-1:0] m_prev, m_pend, m_ptype, m_ovf;
   logic         m_valid, m_rise;
   int           m_id, m_ptr;

   typedef struct {
      logic [3:0] sig;
      logic [7:0] sel;
      logic       rdy;
      logic [3:0] clr;
      logic       v;
      logic [1:0] id;
      logic       r;
      logic [3:0] ov;
   } vec_t;

   vec_t tbl [28];

   always #5 clk = ~clk;

   edge_event_arbiter #(.N_CH(N)) dut (
      .clk       (clk),
      .reset     (reset),
      .sig_in    (sig_in),
      .edge_sel  (edge_sel),
      .evt_valid (evt_valid),
      .evt_ready (evt_ready),
      .evt_id    (evt_id),
      .evt_rise  (evt_rise),
      .ovf       (ovf),
      .ovf_clr   (ovf_clr)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_prev  = '0;
      m_pend  = '0;
      m_ptype = '0;
      m_ovf   = '0;
      m_valid = 1'b0;
      m_rise  = 1'b0;
      m_id    = 0;
      m_ptr   = N - 1;
   endtask

   // One clock of the event-level behaviour, using the inputs present at the edge.
   task automatic model_step();
      int win = -1;
      if (!m_valid || evt_ready)
         for (int k = 1; k <= N; k++)
            if (win < 0 && m_pend[(m_ptr + k) % N]) win = (m_ptr + k) % N;
      if (win >= 0) begin
         m_valid = 1'b1;
         m_id    = win;
         m_rise  = m_ptype[win];
         m_ptr   = win;
      end else if (evt_ready) begin
         m_valid = 1'b0;
      end
      for (int c = 0; c < N; c++) begin
         logic r, f, want;
         logic [1:0] md;
         md   = edge_sel[2*c +: 2];
         r    = sig_in[c] && !m_prev[c];
         f    = !sig_in[c] && m_prev[c];
         want = (r && md[0]) || (f && md[1]);
         if (ovf_clr[c]) m_ovf[c] = 1'b0;
         if (md == 2'b00) m_pend[c] = 1'b0;
         else if (want && m_pend[c] && c != win) m_ovf[c] = 1'b1;
         else if (want) begin
            m_pend[c]  = 1'b1;
            m_ptype[c] = r;
         end else if (c == win) m_pend[c] = 1'b0;
         m_prev[c] = sig_in[c];
      end
   endtask

   // Advance one clock, then compare DUT against the model; also check stall stability.
   task automatic tick();
      logic       stall, srise;
      logic [1:0] sid;
      stall = evt_valid && !evt_ready;
      sid   = evt_id;
      srise = evt_rise;
      @(posedge clk);
      model_step();
      #1;
      chk("model_valid", evt_valid, m_valid);
      chk("model_id", evt_id, m_id);
      chk("model_rise", evt_rise, m_rise);
      chk("model_ovf", ovf, m_ovf);
      if (stall) begin
         chk("stall_valid", evt_valid, 1);
         chk("stall_id", evt_id, sid);
         chk("stall_rise", evt_rise, srise);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = '{4'b0001, 8'h55, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0000};
      tbl[1]  = '{4'b0001, 8'h55, 1'b1, 4'b0000, 1'b1, 2'd0, 1'b1, 4'b0000};
      tbl[2]  = '{4'b0001, 8'h55, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b1, 4'b0000};
      tbl[3]  = '{4'b1011, 8'h55, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b1, 4'b0000};
      tbl[4]  = '{4'b1011, 8'h55, 1'b1, 4'b0000, 1'b1, 2'd1, 1'b1, 4'b0000};
      tbl[5]  = '{4'b1011, 8'h55, 1'b1, 4'b0000, 1'b1, 2'd3, 1'b1, 4'b0000};
      tbl[6]  = '{4'b1011, 8'h55, 1'b1, 4'b0000, 1'b0, 2'd3, 1'b1, 4'b0000};
      tbl[7]  = '{4'b0000, 8'h55, 1'b1, 4'b0000, 1'b0, 2'd3, 1'b1, 4'b0000};
      tbl[8]  = '{4'b1001, 8'h55, 1'b1, 4'b0000, 1'b0, 2'd3, 1'b1, 4'b0000};
      tbl[9]  = '{4'b1001, 8'h55, 1'b1, 4'b0000, 1'b1, 2'd0, 1'b1, 4'b0000};
      tbl[10] = '{4'b1001, 8'h55, 1'b1, 4'b0000, 1'b1, 2'd3, 1'b1, 4'b0000};
      tbl[11] = '{4'b1001, 8'h55, 1'b1, 4'b0000, 1'b0, 2'd3, 1'b1, 4'b0000};
      tbl[12] = '{4'b1101, 8'h75, 1'b0, 4'b0000, 1'b0, 2'd3, 1'b1, 4'b0000};
      tbl[13] = '{4'b1001, 8'h75, 1'b0, 4'b0000, 1'b1, 2'd2, 1'b1, 4'b0000};
      tbl[14] = '{4'b1101, 8'h75, 1'b0, 4'b0000, 1'b1, 2'd2, 1'b1, 4'b0100};
      tbl[15] = '{4'b1101, 8'h75, 1'b0, 4'b0000, 1'b1, 2'd2, 1'b1, 4'b0100};
      tbl[16] = '{4'b1101, 8'h75, 1'b1, 4'b0000, 1'b1, 2'd2, 1'b0, 4'b0100};
      tbl[17] = '{4'b1101, 8'h75, 1'b1, 4'b0100, 1'b0, 2'd2, 1'b0, 4'b0000};
      tbl[18] = '{4'b1000, 8'h54, 1'b1, 4'b0000, 1'b0, 2'd2, 1'b0, 4'b0000};
      tbl[19] = '{4'b1001, 8'h56, 1'b1, 4'b0000, 1'b0, 2'd2, 1'b0, 4'b0000};
      tbl[20] = '{4'b1001, 8'h56, 1'b1, 4'b0000, 1'b0, 2'd2, 1'b0, 4'b0000};
      tbl[21] = '{4'b1000, 8'h56, 1'b1, 4'b0000, 1'b0, 2'd2, 1'b0, 4'b0000};
      tbl[22] = '{4'b1000, 8'h56, 1'b1, 4'b0000, 1'b1, 2'd0, 1'b0, 4'b0000};
      tbl[23] = '{4'b1000, 8'h56, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0000};
      tbl[24] = '{4'b1011, 8'h55, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0000};
      tbl[25] = '{4'b1011, 8'h54, 1'b0, 4'b0000, 1'b1, 2'd1, 1'b1, 4'b0000};
      tbl[26] = '{4'b1011, 8'h55, 1'b1, 4'b0000, 1'b0, 2'd1, 1'b1, 4'b0000};
      tbl[27] = '{4'b1011, 8'h55, 1'b1, 4'b0000, 1'b0, 2'd1, 1'b1, 4'b0000};

      reset     = 1'b1;
      sig_in    = '0;
      edge_sel  = 8'h55;
      evt_ready = 1'b1;
      ovf_clr   = '0;
      model_reset();
      #12;
      chk("rst_valid", evt_valid, 0);
      chk("rst_id", evt_id, 0);
      chk("rst_rise", evt_rise, 0);
      chk("rst_ovf", ovf, 0);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 28; i++) begin
         sig_in    = tbl[i].sig;
         edge_sel  = tbl[i].sel;
         evt_ready = tbl[i].rdy;
         ovf_clr   = tbl[i].clr;
         tick();
         chk($sformatf("tbl%0d_valid", i), evt_valid, tbl[i].v);
         chk($sformatf("tbl%0d_id", i), evt_id, tbl[i].id);
         chk($sformatf("tbl%0d_rise", i), evt_rise, tbl[i].r);
         chk($sformatf("tbl%0d_ovf", i), ovf, tbl[i].ov);
      end

      // Build a stalled event plus an overflow on channel 2, then reset mid-handshake.
      edge_sel  = 8'h55;
      ovf_clr   = '0;
      evt_ready = 1'b0;
      sig_in    = 4'b1111; tick(); tick();
      chk("pre_rst_valid", evt_valid, 1);
      chk("pre_rst_id", evt_id, 2);
      sig_in    = 4'b1011; tick();
      sig_in    = 4'b1111; tick();
      sig_in    = 4'b1011; tick();
      sig_in    = 4'b1111; tick();
      chk("pre_rst_ovf", ovf, 4'b0100);
      #2;
      reset = 1'b1;
      #1;
      chk("async_rst_valid", evt_valid, 0);
      chk("async_rst_id", evt_id, 0);
      chk("async_rst_rise", evt_rise, 0);
      chk("async_rst_ovf", ovf, 0);
      model_reset();
      evt_ready = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      tick();
      chk("post_rst_idle", evt_valid, 0);
      for (int k = 0; k < 4; k++) begin
         tick();
         chk($sformatf("post_rst_ev%0d_valid", k), evt_valid, 1);
         chk($sformatf("post_rst_ev%0d_id", k), evt_id, k);
         chk($sformatf("post_rst_ev%0d_rise", k), evt_rise, 1);
      end
      tick();
      chk("post_rst_drain", evt_valid, 0);

      for (int n = 0; n < 10000; n++) begin
         if (n % 64 == 0) edge_sel = 8'($urandom);
         sig_in    = 4'($urandom);
         evt_ready = ($urandom_range(0, 3) != 0);
         ovf_clr   = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
